irq_requester: RTL

//  Peripheral-side interrupt requester; drives the core IRQ unit's inirr vector and consumes its outirr acknowledge vector.
//  Per line it detects edge or level events, holds the request until the core acknowledges, and handles re-arm.
//  It also flags lost events. Sits between peripheral event wires and the core IRQ block, one instance per core.

---
 rtl/irq_pkg.sv | 14 +
 rtl/irq_requester_if.sv | 29 ++
 rtl/irq_line.sv | 86 ++++++++
 rtl/irq_requester.sv | 45 ++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt requester: line state codes and default sizes.
package irq_pkg;

   localparam int unsigned NIRQ_DEF = 32;
   localparam int unsigned CNTW_DEF = 6;

   // Per-line request state; code 3 is unused and recovers to IRQ_IDLE
   typedef enum logic [1:0] {
      IRQ_IDLE = 2'd0,
      IRQ_PEND = 2'd1,
      IRQ_SERV = 2'd2
   } irq_state_e;

endpackage

// File: rtl/irq_requester_if.sv
// Bundle between peripheral/core side (master) and the interrupt requester (slave).
interface irq_requester_if
   import irq_pkg::*;
#(
   parameter int unsigned NIRQ = NIRQ_DEF,
   parameter int unsigned CNTW = CNTW_DEF
) ();

   logic [NIRQ-1:0] ev;
   logic [NIRQ-1:0] edge_sel;
   logic [NIRQ-1:0] en_mask;
   logic [NIRQ-1:0] outirr;
   logic [NIRQ-1:0] lost_clr;
   logic [NIRQ-1:0] inirr;
   logic [NIRQ-1:0] lost;
   logic            any_pend;
   logic [CNTW-1:0] pend_cnt;

   modport master (
      output ev, edge_sel, en_mask, outirr, lost_clr,
      input  inirr, lost, any_pend, pend_cnt
   );

   modport slave (
      input  ev, edge_sel, en_mask, outirr, lost_clr,
      output inirr, lost, any_pend, pend_cnt
   );

endinterface

// File: rtl/irq_line.sv
// One interrupt line: event detection, request/service state, re-arm and lost-event flag.
module irq_line
   import irq_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_ev,
   input  logic i_edge_sel,
   input  logic i_en_mask,
   input  logic i_outirr,
   input  logic i_lost_clr,
   output logic o_inirr,
   output logic o_lost
);

   irq_state_e r_state;
   logic       r_ev_q;
   logic       r_rearm;
   logic       r_lost;
   logic       r_inirr;
   logic       w_trig;

   // Trigger: rising edge or level of the event, gated by the enable
   assign w_trig = i_en_mask & (i_edge_sel ? (i_ev & ~r_ev_q) : i_ev);

   // Line FSM; request output is registered alongside the state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IRQ_IDLE;
         r_inirr <= 1'b0;
         r_lost  <= 1'b0;
         r_rearm <= 1'b0;
         r_ev_q  <= i_ev;
      end else begin
         r_ev_q <= i_ev;
         if (i_lost_clr) begin
            r_lost <= 1'b0;
         end
         case (r_state)
            IRQ_IDLE: begin
               if (w_trig) begin
                  r_state <= IRQ_PEND;
                  r_inirr <= 1'b1;
               end
            end
            IRQ_PEND: begin
               if (i_outirr) begin
                  r_state <= IRQ_SERV;
                  r_inirr <= 1'b0;
                  r_rearm <= w_trig;
               end else if (!i_en_mask) begin
                  r_state <= IRQ_IDLE;
                  r_inirr <= 1'b0;
               end else if (w_trig) begin
                  r_lost <= 1'b1;
               end
            end
            IRQ_SERV: begin
               if (i_edge_sel) begin
                  // Edge mode leaves service after one cycle; a pending re-arm re-requests
                  r_rearm <= 1'b0;
                  if (r_rearm || w_trig) begin
                     r_state <= IRQ_PEND;
                     r_inirr <= 1'b1;
                  end else begin
                     r_state <= IRQ_IDLE;
                  end
               end else if (!i_ev) begin
                  // Level mode waits for the source to drop, avoiding a retrigger storm
                  r_state <= IRQ_IDLE;
                  r_rearm <= 1'b0;
               end
            end
            default: begin
               r_state <= IRQ_IDLE;
               r_inirr <= 1'b0;
               r_rearm <= 1'b0;
            end
         endcase
      end
   end

   assign o_inirr = r_inirr;
   assign o_lost  = r_lost;

endmodule

// File: rtl/irq_requester.sv
// Peripheral-side interrupt requester: NIRQ independent lines plus pending summary.
module irq_requester
   import irq_pkg::*;
#(
   parameter int unsigned NIRQ = NIRQ_DEF,
   parameter int unsigned CNTW = CNTW_DEF
) (
   input logic             clk,
   input logic             rst,
   irq_requester_if.slave  bus
);

   logic [NIRQ-1:0] w_inirr;
   logic [NIRQ-1:0] w_lost;
   logic [CNTW-1:0] w_cnt;

   // One independent requester per interrupt line
   for (genvar g = 0; g < NIRQ; g++) begin : g_line
      irq_line u_line (
         .clk        (clk),
         .rst        (rst),
         .i_ev       (bus.ev[g]),
         .i_edge_sel (bus.edge_sel[g]),
         .i_en_mask  (bus.en_mask[g]),
         .i_outirr   (bus.outirr[g]),
         .i_lost_clr (bus.lost_clr[g]),
         .o_inirr    (w_inirr[g]),
         .o_lost     (w_lost[g])
      );
   end

   // Count of lines currently requesting
   always_comb begin
      w_cnt = '0;
      for (int i = 0; i < int'(NIRQ); i++) begin
         w_cnt = w_cnt + CNTW'(w_inirr[i]);
      end
   end

   assign bus.inirr    = w_inirr;
   assign bus.lost     = w_lost;
   assign bus.any_pend = |w_inirr;
   assign bus.pend_cnt = w_cnt;

endmodule
